// File: rtl/audio_rx_pkg.sv
// Shared types and constants for the codec ADC receive path.
// Imported by the synchronizer and the deserializer.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    ALIGN,
    SKIP,
    SHIFT,
    HOLD
  } rx_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int AUDIO_WIDTH = 16;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with one delay flop for edge detection.
// Level and pulses come out aligned at the same pipeline depth.
module sync_edge
  import audio_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign rise     = level & ~dly_q;
  assign fall     = ~level & dly_q;
  assign any_edge = level ^ dly_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// WM8731 ADC stream deserializer, oversampled in the CLOCK_50 domain.
// Delivers left/right pairs over a valid/ready handshake.
module i2s_adc_receiver
  import audio_rx_pkg::*;
#(
  parameter int   WIDTH     = AUDIO_WIDTH,
  parameter logic LEFT_LRCK = 1'b0,
  parameter int   I2S_DELAY = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             AUD_BCLK,
  input  logic             AUD_ADCLRCK,
  input  logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] ADC_LDATA,
  output logic [WIDTH-1:0] ADC_RDATA,
  output logic             adc_valid,
  input  logic             adc_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int SKW = (I2S_DELAY < 2) ? 1 : $clog2(I2S_DELAY + 1);

  logic bclk_rise;
  logic lrck;
  logic lrck_edge;
  logic dat;

  logic unused_bclk_lvl, unused_bclk_fall, unused_bclk_any;
  logic unused_lrck_rise, unused_lrck_fall;
  logic unused_dat_rise, unused_dat_fall, unused_dat_any;

  sync_edge u_bclk (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .din      (AUD_BCLK),
    .level    (unused_bclk_lvl),
    .rise     (bclk_rise),
    .fall     (unused_bclk_fall),
    .any_edge (unused_bclk_any)
  );

  sync_edge u_lrck (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .din      (AUD_ADCLRCK),
    .level    (lrck),
    .rise     (unused_lrck_rise),
    .fall     (unused_lrck_fall),
    .any_edge (lrck_edge)
  );

  sync_edge u_dat (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .din      (AUD_ADCDAT),
    .level    (dat),
    .rise     (unused_dat_rise),
    .fall     (unused_dat_fall),
    .any_edge (unused_dat_any)
  );

  rx_state_t        state, state_n;
  logic [SKW-1:0]   skip_cnt, skip_n;
  logic [BCW-1:0]   bitcnt, bit_n;
  logic [WIDTH-2:0] shreg, shreg_n;
  logic [WIDTH-1:0] left_stage, left_n;
  logic             have_left, have_left_n;
  logic [WIDTH-1:0] word;
  logic             start;
  logic             pair_done;
  logic             fe_set;
  logic             ovr_set;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ALIGN;
      skip_cnt   <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      left_stage <= '0;
      have_left  <= 1'b0;
    end else begin
      state      <= state_n;
      skip_cnt   <= skip_n;
      bitcnt     <= bit_n;
      shreg      <= shreg_n;
      left_stage <= left_n;
      have_left  <= have_left_n;
    end
  end

  always_comb begin
    state_n     = state;
    skip_n      = skip_cnt;
    bit_n       = bitcnt;
    shreg_n     = shreg;
    left_n      = left_stage;
    have_left_n = have_left;
    word        = {shreg, dat};
    start       = 1'b0;
    pair_done   = 1'b0;
    fe_set      = 1'b0;
    unique case (state)
      ALIGN: start = lrck_edge && (lrck == LEFT_LRCK);
      SKIP, SHIFT: begin
        if (lrck_edge) begin
          // short word: drop it, resync only on a left channel
          fe_set      = 1'b1;
          have_left_n = 1'b0;
          if (lrck == LEFT_LRCK) start = 1'b1;
          else                   state_n = ALIGN;
        end else if (bclk_rise) begin
          if (state == SKIP) begin
            if (skip_cnt <= SKW'(1)) begin
              state_n = SHIFT;
              bit_n   = '0;
            end else begin
              skip_n = skip_cnt - 1'b1;
            end
          end else begin
            shreg_n = word[WIDTH-2:0];
            if (bitcnt != BCW'(WIDTH)) bit_n = bitcnt + 1'b1;
            if (bitcnt == BCW'(WIDTH - 1)) begin
              state_n = HOLD;
              if (lrck == LEFT_LRCK) begin
                left_n      = word;
                have_left_n = 1'b1;
              end else begin
                pair_done   = have_left;
                have_left_n = 1'b0;
              end
            end
          end
        end
      end
      HOLD:    start = lrck_edge;
      default: state_n = ALIGN;
    endcase
    if (start) begin
      state_n = (I2S_DELAY == 0) ? SHIFT : SKIP;
      skip_n  = SKW'(I2S_DELAY);
      bit_n   = '0;
      if (lrck == LEFT_LRCK) have_left_n = 1'b0;
    end
  end

  assign ovr_set = pair_done & adc_valid & ~adc_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ADC_LDATA <= '0;
      ADC_RDATA <= '0;
      adc_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (pair_done) begin
        ADC_LDATA <= left_stage;
        ADC_RDATA <= word;
        adc_valid <= 1'b1;
      end else if (adc_valid && adc_ready) begin
        adc_valid <= 1'b0;
      end
      overrun   <= ovr_set | (overrun & ~err_clr);
      frame_err <= fe_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for the I2S ADC receiver.
// Drives codec-style frames and scoreboards delivered pairs.
module tb_i2s_adc_receiver;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic [15:0] ADC_LDATA;
  logic [15:0] ADC_RDATA;
  logic        adc_valid;
  logic        adc_ready;
  logic        overrun;
  logic        frame_err;
  logic        err_clr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pair;
  bit          lat_chk = 1'b0;
  bit          accept_at_done = 1'b0;

  always #5 Clk = ~Clk;

  i2s_adc_receiver dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .ADC_LDATA   (ADC_LDATA),
    .ADC_RDATA   (ADC_RDATA),
    .adc_valid   (adc_valid),
    .adc_ready   (adc_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .err_clr     (err_clr)
  );

  // scoreboard: a handshake seen before the next posedge must match the queue head
  always begin
    @(negedge Clk);
    #2;
    if (Reset_n && adc_valid && adc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pair got %h/%h, none expected", ADC_LDATA, ADC_RDATA);
      end else begin
        exp_pair = exp_q.pop_front();
        if ({ADC_LDATA, ADC_RDATA} !== exp_pair) begin
          errors++;
          $display("FAIL pair got %h/%h expected %h/%h",
                   ADC_LDATA, ADC_RDATA, exp_pair[31:16], exp_pair[15:0]);
        end
      end
    end
  end

  // one BCLK period (16 Clk), entered and left on a Clk negedge
  task automatic bclk_cycle(input logic lr, input logic d, input bit done);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (8) @(negedge Clk);
    AUD_BCLK = 1'b1;
    if (done && (lat_chk || accept_at_done)) begin
      repeat (2) @(negedge Clk);
      if (lat_chk) begin
        checks++;
        if (adc_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_early got %b expected 0", adc_valid);
        end
      end
      if (accept_at_done) adc_ready = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (adc_valid !== 1'b1) begin
        errors++;
        $display("FAIL valid_latency got %b expected 1", adc_valid);
      end
      if (accept_at_done) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_on_accept got %b expected 0", overrun);
        end
      end
      repeat (6) @(negedge Clk);
    end else begin
      repeat (8) @(negedge Clk);
    end
  endtask

  task automatic send_chan(input logic lr, input logic [15:0] w, input int n);
    logic d;
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= 16) d = w[16-i];
      else                   d = 1'($urandom_range(0, 1));
      bclk_cycle(lr, d, (lr == 1'b1) && (i == 16));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n);
    send_chan(1'b0, l, n);
    send_chan(1'b1, r, n);
  endtask

  task automatic pulse_clr();
    @(negedge Clk);
    err_clr = 1'b1;
    @(negedge Clk);
    err_clr = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if (adc_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b o=%b f=%b expected 0", adc_valid, overrun, frame_err);
    end
    checks++;
    if (ADC_LDATA !== 16'h0 || ADC_RDATA !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h expected 0000/0000", ADC_LDATA, ADC_RDATA);
    end
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_basic();
    adc_ready = 1'b0;
    lat_chk   = 1'b1;
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_frame(16'hA5C3, 16'h1234, 17);
    lat_chk = 1'b0;
    checks++;
    if (ADC_LDATA !== 16'hA5C3 || ADC_RDATA !== 16'h1234 || adc_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold got %h/%h v=%b expected a5c3/1234 v=1",
               ADC_LDATA, ADC_RDATA, adc_valid);
    end
    adc_ready = 1'b1;
    repeat (3) @(negedge Clk);
    #2;
    checks++;
    if (adc_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept got v=%b expected 0", adc_valid);
    end
  endtask

  task automatic test_long_word();
    adc_ready = 1'b1;
    exp_q.push_back({16'h8001, 16'h7FFE});
    send_frame(16'h8001, 16'h7FFE, 32);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL long_word_frame_err got %b expected 0", frame_err);
    end
  endtask

  task automatic test_overrun();
    adc_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 17);
    exp_q.push_back({16'h3333, 16'h4444});
    send_frame(16'h3333, 16'h4444, 17);
    #2;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b expected 1", overrun);
    end
    checks++;
    if (ADC_LDATA !== 16'h3333 || ADC_RDATA !== 16'h4444 || adc_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_data got %h/%h v=%b expected 3333/4444 v=1",
               ADC_LDATA, ADC_RDATA, adc_valid);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr got %b expected 0", overrun);
    end
    adc_ready = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_frame_err();
    adc_ready = 1'b1;
    send_chan(1'b0, 16'hFFFF, 10);
    send_chan(1'b1, 16'h5555, 17);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_set got %b expected 1", frame_err);
    end
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    send_frame(16'h0F0F, 16'hF0F0, 17);
    repeat (3) @(negedge Clk);
    #2;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_sticky got %b expected 1", frame_err);
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clr got %b expected 0", frame_err);
    end
  endtask

  task automatic test_reset_mid();
    adc_ready = 1'b0;
    send_frame(16'h5555, 16'hAAAA, 17);
    send_chan(1'b0, 16'h1234, 17);
    send_chan(1'b1, 16'h5678, 8);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (adc_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 ||
        ADC_LDATA !== 16'h0 || ADC_RDATA !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset got %h/%h v=%b o=%b f=%b expected all 0",
               ADC_LDATA, ADC_RDATA, adc_valid, overrun, frame_err);
    end
    repeat (2) @(negedge Clk);
    Reset_n   = 1'b1;
    adc_ready = 1'b1;
    send_chan(1'b1, 16'h0000, 9);
    exp_q.push_back({16'h9ABC, 16'hDEF0});
    send_frame(16'h9ABC, 16'hDEF0, 17);
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    adc_ready = 1'b0;
    exp_q.push_back({16'hC0DE, 16'hBEEF});
    send_frame(16'hC0DE, 16'hBEEF, 17);
    exp_q.push_back({16'h1357, 16'h2468});
    accept_at_done = 1'b1;
    send_frame(16'h1357, 16'h2468, 17);
    accept_at_done = 1'b0;
    repeat (2) @(negedge Clk);
    #2;
    checks++;
    if (adc_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got v=%b o=%b expected 0/0", adc_valid, overrun);
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b1;
    AUD_ADCDAT  = 1'b0;
    adc_ready   = 1'b0;
    err_clr     = 1'b0;
    test_reset();
    test_basic();
    test_long_word();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_pairs got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
